// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry pipeline skid register.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package pipe_pkg;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Widest payload supported; the NOP bubble is sliced down to DATA_W.
  localparam int NOP_W = 1024;
  localparam logic [NOP_W-1:0] NOP = '0;

  // Number of held entries for a given state.
  function automatic logic [1:0] occ_of(input state_e st);
    return logic'(st == ST_FULL) ? 2'd2 : (logic'(st == ST_ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one edge later.
// Backpressure: none; holds at all-ones once saturated.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with flush and stall counter.
// Latency: one edge from accept to out_valid when empty; strict FIFO order.
// Backpressure: in_ready is a flop, low only while both entries are held.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [DATA_W-1:0] NOP_DAT = NOP[DATA_W-1:0];

  state_e            state_q,    state_d;
  logic [DATA_W-1:0] main_q,     main_d;
  logic [DATA_W-1:0] skid_q,     skid_d;
  logic              in_ready_q, in_ready_d;

  logic accept;
  logic pop;
  logic stall_inc;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occ_of(state_q);

  // Handshakes are masked by flush so a flushed cycle neither accepts nor pops.
  assign accept    = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign stall_inc = out_valid & ~out_ready & ~flush;

  // Next-state and datapath: flush empties everything, otherwise move entries by state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_DAT;
      skid_d  = NOP_DAT;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (pop) begin
            main_d  = NOP_DAT;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move data.
          if (pop) begin
            main_d  = skid_q;
            skid_d  = NOP_DAT;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_DAT;
          skid_d  = NOP_DAT;
        end
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State, payload and ready registers; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_DAT;
      skid_q     <= NOP_DAT;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .inc (stall_inc),
    .clr (reset),
    .cnt (stall_cnt)
  );

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (instruction in bits [63:32], PC in bits [31:0] at default).
REQ-002 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all held entries; higher priority than any handshake.
REQ-006 in_valid  input  1  upstream stage offers in_data.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  block can accept; SHALL be driven directly from a flop.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  DATA_W  head-entry payload.
REQ-011 out_ready  input  1  downstream consumes the head this cycle.
REQ-012 occupancy  output  2  number of held entries, 0..2.
REQ-013 stall_cnt  output  CNT_W  saturating count of stalled output cycles.

Function
REQ-014 Accept SHALL be in_valid & in_ready & !flush; pop SHALL be out_valid & out_ready & !flush.
REQ-015 The FSM SHALL have states EMPTY (occ 0), ONE (occ 1, main only) and FULL (occ 2, main plus skid).
REQ-016 In EMPTY, accept SHALL load main and move to ONE.
REQ-017 In ONE, accept with pop SHALL load main and stay in ONE.
REQ-018 In ONE, accept without pop SHALL load skid and move to FULL.
REQ-019 In ONE, pop without accept SHALL move to EMPTY.
REQ-020 In FULL, in_ready SHALL be 0; pop SHALL copy skid to main, clear skid, and move to ONE.
REQ-021 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except on flush.
REQ-022 Latency: data accepted at edge N SHALL appear on out_data with out_valid=1 immediately after edge N when the block was EMPTY.
REQ-023 in_ready SHALL be registered: its next value is 0 exactly when the next state is FULL, otherwise 1.
REQ-024 out_valid SHALL equal (state != EMPTY); out_data SHALL be main, and main SHALL be all-zero (NOP bubble) whenever out_valid=0.
REQ-025 Flush SHALL, at the next edge, force EMPTY, zero main and skid, set in_ready=1, and drop any same-cycle input; it SHALL NOT count as a pop.
REQ-026 Flush asserted on consecutive cycles SHALL keep the block EMPTY.
REQ-027 stall_cnt SHALL increment by 1 on each edge where out_valid=1, out_ready=0 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-028 stall_cnt SHALL NOT be cleared by flush.
REQ-029 in_valid with in_ready=0 SHALL have no effect; upstream holds its data.

Reset
REQ-030 When reset=1 at an edge: state EMPTY, out_valid=0, out_data=0, skid=0, in_ready=1, occupancy=0, stall_cnt=0.
REQ-031 Reset SHALL take priority over flush and all handshakes, including mid-transfer in FULL.

Structure
REQ-032 Package pipe_pkg SHALL hold the state-encoding typedef (EMPTY=0, ONE=1, FULL=2) and the NOP constant (all zero).
REQ-033 The saturating counter SHALL be a sub-module, pipe_sat_cnt, parameterised by CNT_W with inputs inc and clr.

Verification
REQ-034 Reset, then in_valid=1 with data 0x0000000C_00003000 and out_ready=1 -> out_valid=1 and out_data=0x0000000C_00003000 one edge later; occupancy=1.
REQ-035 out_ready=0 while pushing A, B, then C -> occupancy=2, in_ready=0 after B, C held off; releasing out_ready -> out_data sequence A, B, C.
REQ-036 In FULL, assert flush with in_valid=1 -> next cycle occupancy=0, out_data=0, in_ready=1, and the offered data never appears.
REQ-037 Hold out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt=65535 and remains there.
REQ-038 Assert reset in FULL with stall_cnt=5 -> all outputs take their REQ-030 values at the next edge.
REQ-039 Random valid/ready stimulus over 10000 cycles with a scoreboard -> zero ordering or data mismatches, and in_ready matches REQ-023 every cycle.
